// File: rtl/shift_pkg.sv
// Shared definitions for the shift sequencer: FSM state encoding and direction constants.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_step_1b.sv
// Combinational one-position logical shift; vacated bit is zero, shifted-out bit is dropped.
module shift_step_1b
    import shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] d,
    input  logic             dir,
    output logic [WIDTH-1:0] y
);

    assign y = (dir == DIR_LEFT) ? (d << 1) : (d >> 1);

endmodule

// File: rtl/shift_seq_4b.sv
// Sequential shifter: loads an operand, shifts one position per cycle, then holds the result
// under a valid/ready handshake until the consumer takes it.
module shift_seq_4b
    import shift_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int AMT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             busy
);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_shifted;
    logic [AMT_W-1:0] r_cnt;
    logic             r_dir;
    logic             w_load;
    logic             w_step;

    shift_step_1b #(.WIDTH(WIDTH)) u_step (
        .d   (r_q),
        .dir (r_dir),
        .y   (w_shifted)
    );

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_load       = 1'b1;
                    w_next_state = (in_amt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                w_step = 1'b1;
                // The shift on the cnt==1 edge is the final one.
                if (r_cnt == AMT_W'(1)) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_cnt   <= '0;
            r_dir   <= DIR_RIGHT;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_q   <= in_data;
                r_dir <= in_dir;
                r_cnt <= in_amt;
            end else if (w_step) begin
                r_q   <= w_shifted;
                r_cnt <= r_cnt - AMT_W'(1);
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == SHIFT);
    assign q         = r_q;

endmodule

// File: tb/tb_shift_seq_4b.sv
// Randomized self-checking bench for shift_seq_4b against an arithmetic reference model.
module tb_shift_seq_4b;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       in_valid  = 1'b0;
    logic       in_ready;
    logic [3:0] in_data   = '0;
    logic       in_dir    = 1'b0;
    logic [1:0] in_amt    = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] q;
    logic       busy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    shift_seq_4b #(.WIDTH(4), .AMT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Logical shift by k as multiply/divide by 2**k, truncated to 4 bits.
    function automatic int unsigned ref_shift(input logic [3:0] d, input logic dir, input int unsigned k);
        int unsigned v;
        v = dir ? (int'(d) * (1 << k)) : (int'(d) / (1 << k));
        return v % 16;
    endfunction

    // Caller is positioned #1 after a rising edge with the DUT in IDLE.
    task automatic run_txn(input logic [3:0] d, input logic dr, input logic [1:0] a, input int unsigned bp);
        int unsigned res;
        res = ref_shift(d, dr, a);
        check("idle_ready", in_ready, 1);
        in_valid  = 1'b1;
        in_data   = d;
        in_dir    = dr;
        in_amt    = a;
        out_ready = 1'b0;
        for (int unsigned e = 1; e <= int'(a) + 1; e++) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 4'($urandom);
            in_dir   = 1'($urandom);
            in_amt   = 2'($urandom);
            check("q_step", q, ref_shift(d, dr, e - 1));
            check("busy", busy, (e <= int'(a)) ? 1 : 0);
            check("out_valid_rise", out_valid, (e == int'(a) + 1) ? 1 : 0);
            check("in_ready_low", in_ready, 0);
        end
        for (int unsigned c = 0; c < bp; c++) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 4'($urandom);
            check("bp_valid", out_valid, 1);
            check("bp_q", q, res);
            check("bp_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("hs_valid", out_valid, 0);
        check("hs_ready", in_ready, 1);
        check("hs_q_kept", q, res);
        check("hs_busy", busy, 0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        check("rst_q", q, 0);
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_txn(4'b1000, 1'b0, 2'd3, 0);
        run_txn(4'b0001, 1'b1, 2'd2, 0);
        run_txn(4'b1000, 1'b1, 2'd1, 0);
        run_txn(4'b1011, 1'b0, 2'd0, 0);
        run_txn(4'b1011, 1'b1, 2'd0, 1);
        run_txn(4'b0110, 1'b1, 2'd3, 5);

        // Abort in the second SHIFT cycle of an amt=3 operation.
        in_valid = 1'b1;
        in_data  = 4'b1101;
        in_dir   = 1'b0;
        in_amt   = 2'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_q", q, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        for (int unsigned c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("rst_hold_valid", out_valid, 0);
        end
        rst = 1'b0;
        run_txn(4'b0110, 1'b0, 2'd1, 2);

        for (int unsigned t = 0; t < 40; t++) begin
            run_txn(4'($urandom), 1'($urandom), 2'($urandom), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
